program_loader: RTL and testbench

//   Host-side driver of the CPU programming interface. Buffers program words from a

---
 rtl/program_loader.sv | 176 +++++++++++++++++
 tb/tb_program_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: host-side driver of the CPU programming interface.
// Stages host words in a small FIFO. Each CPU read strobe takes one word from
// ui_data, and done_load pulses are counted. Programming mode is released once
// a full image of DEPTH words has been written into CPU RAM.
module program_loader #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_W-1:0]          host_data,
    input  logic                       host_valid,
    output logic                       host_ready,
    output logic                       programming,
    input  logic                       read_ui_in,
    input  logic                       done_load,
    output logic [DATA_W-1:0]          ui_data,
    output logic [$clog2(DEPTH+1)-1:0] loaded_count,
    output logic                       underrun,
    output logic                       load_done
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  occ_next;
    logic [CNT_W-1:0]  accepted;
    logic [DATA_W-1:0] head_next;

    logic in_load;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic flush;
    logic last_done;

    assign in_load    = (state == S_LOAD);
    assign fifo_full  = (occupancy == FULL_OCC);
    assign fifo_empty = (occupancy == '0);

    // Gated by reset so the host never sees a ready during a reset cycle.
    assign host_ready = !reset && in_load && !fifo_full && (accepted < DEPTH_CNT);
    assign push       = host_valid && host_ready;
    assign pop        = in_load && read_ui_in && !fifo_empty;
    assign flush      = (state == S_IDLE) && start;
    assign last_done  = in_load && done_load && (loaded_count == LAST_CNT);

    // Next FIFO pointers and the word that will sit at the head after this edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that skips an assignment infers a latch.
        rd_ptr_next = rd_ptr + PTR_W'(pop);
        occ_next    = occupancy;
        head_next   = '0;
        case ({push, pop})
            2'b10:   occ_next = occupancy + OCC_W'(1);
            2'b01:   occ_next = occupancy - OCC_W'(1);
            default: occ_next = occupancy;
        endcase
        if (flush || occ_next == '0) begin
            head_next = '0;
        end else if (push && wr_ptr == rd_ptr_next) begin
            // The slot being written this edge becomes the head (empty FIFO,
            // or its last word popped in the same cycle).
            head_next = host_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // FIFO storage: write port only.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; occupancy and the head register guarantee no stale word is ever presented.
        if (push) begin
            mem[wr_ptr] <= host_data;
        end
    end

    // Load sequencing: IDLE -> LOAD on start, LOAD -> DONE on the last done_load, DONE -> IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            programming <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        programming <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (last_done) begin
                        state       <= S_DONE;
                        programming <= 1'b0;
                        load_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    programming <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the registered head word shown to the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            ui_data   <= '0;
        end else begin
            ui_data <= head_next;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                rd_ptr    <= rd_ptr_next;
                occupancy <= occ_next;
            end
        end
    end

    // Per-image bookkeeping: accepted words, completed writes, sticky underrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted     <= '0;
            loaded_count <= '0;
            underrun     <= 1'b0;
        end else if (flush) begin
            accepted     <= '0;
            loaded_count <= '0;
            underrun     <= 1'b0;
        end else begin
            if (push) begin
                accepted <= accepted + CNT_W'(1);
            end
            if (in_load && done_load && loaded_count != DEPTH_CNT) begin
                loaded_count <= loaded_count + CNT_W'(1);
            end
            if (in_load && read_ui_in && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven vectors, hand sequences for the multi-cycle
// corner cases, and a randomized run checked against a queue-based model.
module tb_program_loader;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] host_data;
    logic              host_valid;
    logic              host_ready;
    logic              programming;
    logic              read_ui_in;
    logic              done_load;
    logic [DATA_W-1:0] ui_data;
    logic [CNT_W-1:0]  loaded_count;
    logic              underrun;
    logic              load_done;

    int checks   = 0;
    int failures = 0;

    program_loader #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .host_data   (host_data),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .programming (programming),
        .read_ui_in  (read_ui_in),
        .done_load   (done_load),
        .ui_data     (ui_data),
        .loaded_count(loaded_count),
        .underrun    (underrun),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The loader seen as: an "active" flag, a one-cycle "finished" flag, a word
    // queue of at most FIFO_DEPTH entries, and three per-image counters.
    bit          m_loading  = 1'b0;
    bit          m_done     = 1'b0;
    bit          m_underrun = 1'b0;
    int          m_accepted = 0;
    int          m_loaded   = 0;
    int          m_images   = 0;
    logic [7:0]  m_q[$];

    function automatic bit m_ready(input logic rst);
        return !rst && m_loading && (m_q.size() < FIFO_DEPTH) && (m_accepted < DEPTH);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic hv,
                              input logic [7:0] hd, input logic rd, input logic dl);
        bit rdy;
        rdy = m_ready(r);
        if (r) begin
            m_loading  = 1'b0;
            m_done     = 1'b0;
            m_underrun = 1'b0;
            m_accepted = 0;
            m_loaded   = 0;
            m_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_loading) begin
            if (s) begin
                m_q.delete();
                m_accepted = 0;
                m_loaded   = 0;
                m_underrun = 1'b0;
                m_loading  = 1'b1;
            end
        end else begin
            if (rd) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else                m_underrun = 1'b1;
            end
            if (hv && rdy) begin
                m_q.push_back(hd);
                m_accepted++;
            end
            if (dl && m_loaded < DEPTH) begin
                m_loaded++;
                if (m_loaded == DEPTH) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                    m_images++;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [7:0] exp_ui;
        exp_ui = (m_q.size() > 0) ? m_q[0] : 8'h00;
        check("model.programming",  programming,  32'(m_loading));
        check("model.host_ready",   host_ready,   32'(m_ready(reset)));
        check("model.ui_data",      ui_data,      32'(exp_ui));
        check("model.loaded_count", loaded_count, 32'(m_loaded));
        check("model.underrun",     underrun,     32'(m_underrun));
        check("model.load_done",    load_done,    32'(m_done));
    endtask

    // Apply one cycle of inputs, clock it, advance the model, compare #1 after the edge.
    task automatic drive(input logic r, input logic s, input logic hv,
                         input logic [7:0] hd, input logic rd, input logic dl);
        reset      = r;
        start      = s;
        host_valid = hv;
        host_data  = hd;
        read_ui_in = rd;
        done_load  = dl;
        @(posedge clk);
        model_step(r, s, hv, hd, rd, dl);
        #1;
        compare_model();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       r, s, hv;
        logic [7:0] hd;
        logic       rd, dl;
        logic       e_prog, e_rdy;
        logic [7:0] e_ui;
        int         e_cnt;
        logic       e_und, e_ld;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int acc_seen;

        reset      = 1'b1;
        start      = 1'b0;
        host_data  = 8'h00;
        host_valid = 1'b0;
        read_ui_in = 1'b0;
        done_load  = 1'b0;

        // Reset held two cycles with traffic on every input.
        drive(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        check("rst.programming",  programming,  0);
        check("rst.host_ready",   host_ready,   0);
        check("rst.ui_data",      ui_data,      0);
        check("rst.loaded_count", loaded_count, 0);
        check("rst.underrun",     underrun,     0);
        idle();

        // Underrun, push-after-underrun, start ignored in LOAD, strobes ignored in IDLE.
        //           r     s     hv    hd     rd    dl    prog  rdy   ui     cnt und   ld
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].hv, tbl[i].hd, tbl[i].rd, tbl[i].dl);
            check($sformatf("vec%0d.programming", i),  programming,  32'(tbl[i].e_prog));
            check($sformatf("vec%0d.host_ready", i),   host_ready,   32'(tbl[i].e_rdy));
            check($sformatf("vec%0d.ui_data", i),      ui_data,      32'(tbl[i].e_ui));
            check($sformatf("vec%0d.loaded_count", i), loaded_count, tbl[i].e_cnt);
            check($sformatf("vec%0d.underrun", i),     underrun,     32'(tbl[i].e_und));
            check($sformatf("vec%0d.load_done", i),    load_done,    32'(tbl[i].e_ld));
        end

        // Full image 0x40..0x4F with read/done pairs.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        check("img.full_ready", host_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("img.ui_at_read%0d", i), ui_data, 32'(8'h40 + i));
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            drive(1'b0, 1'b0, (i + 4 < DEPTH), 8'(8'h44 + i), 1'b0, 1'b1);
        end
        check("img.loaded_count", loaded_count, 16);
        check("img.load_done",    load_done,    1);
        check("img.programming",  programming,  0);
        idle();
        check("img.load_done_drop", load_done,   0);
        check("img.prog_idle",      programming, 0);

        // Backpressure and the DEPTH-word acceptance limit.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        acc_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (host_ready) acc_seen++;
            drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
        end
        check("bp.full_not_ready", host_ready, 0);
        drive(1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
        check("bp.still_full", host_ready, 0);
        check("bp.head",       ui_data,    8'h10);
        drive(1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0);
        check("bp.ready_after_pop", host_ready, 1);
        for (int j = 0; j < 40; j++) begin
            if (host_ready) acc_seen++;
            drive(1'b0, 1'b0, 1'b1, 8'(8'h30 + j), logic'(j % 2), 1'b0);
        end
        check("bp.accepted_total", acc_seen,   16);
        check("bp.no_17th",        host_ready, 0);
        check("bp.drained_ui",     ui_data,    0);

        // Reset in the middle of a load after 5 done_loads, then a fresh image.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
        check("mid.loaded_count", loaded_count, 5);
        check("mid.head",         ui_data,      8'h65);
        drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        check("mid.rst_programming",  programming,  0);
        check("mid.rst_host_ready",   host_ready,   0);
        check("mid.rst_ui_data",      ui_data,      0);
        check("mid.rst_loaded_count", loaded_count, 0);
        check("mid.rst_underrun",     underrun,     0);
        idle();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("mid.restart_count", loaded_count, 0);
        check("mid.restart_ui",    ui_data,      0);
        check("mid.restart_prog",  programming,  1);
        drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        check("mid.fresh_head", ui_data, 8'h77);

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        m_images = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, s;
            r = ($urandom_range(0, 299) == 0);
            s = m_loading ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
            drive(r, s, logic'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end
        check("rand.images_completed", (m_images > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
